// File: rtl/cmp_pkg.sv
// Shared types and helpers for the iterative branch comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } cmp_state_e;

  // Width of the chunk index; at least one bit even for a single chunk.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned less-than / equal on one W-bit chunk.
module chunk_cmp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt,
  output logic         o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/branch_cmp_seq.sv
// Iterative MSB-first branch comparator: CHUNK bits per cycle, signed/unsigned,
// valid/ready on both sides with registered results.
module branch_cmp_seq
  import cmp_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_br_un,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_br_less,
  output logic            o_br_equal
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
    $error("branch_cmp_seq: XLEN must be a multiple of CHUNK");
  end

  cmp_state_e      r_state;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [IDXW-1:0] r_idx;
  logic            r_diff;
  logic            r_lt;
  logic            r_ready;
  logic            r_valid;
  logic            r_less;
  logic            r_equal;

  logic [XLEN-1:0] w_sign_mask;
  logic            w_lt;
  logic            w_eq;
  logic            w_first_diff;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_sign_mask = {~i_br_un, {(XLEN-1){1'b0}}};

  // Operands shift left each cycle, so the chunk under test is always on top.
  chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
    .i_a  (r_a[XLEN-1 -: CHUNK]),
    .i_b  (r_b[XLEN-1 -: CHUNK]),
    .o_lt (w_lt),
    .o_eq (w_eq)
  );

  assign w_first_diff = ~w_eq & ~r_diff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= IDX_LAST;
      r_diff  <= 1'b0;
      r_lt    <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_less  <= 1'b0;
      r_equal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a     <= i_rs1_data ^ w_sign_mask;
            r_b     <= i_rs2_data ^ w_sign_mask;
            r_idx   <= IDX_LAST;
            r_diff  <= 1'b0;
            r_lt    <= 1'b0;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_a <= r_a << CHUNK;
          r_b <= r_b << CHUNK;
          if (w_first_diff) begin
            r_diff <= 1'b1;
            r_lt   <= w_lt;
          end
          if (EARLY_EXIT && w_first_diff) begin
            r_less  <= w_lt;
            r_equal <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            // A difference found on this last chunk still counts as the first one.
            r_less  <= r_diff ? r_lt : w_lt;
            r_equal <= ~r_diff & w_eq;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_br_less  = r_less;
  assign o_br_equal = r_equal;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Self-checking bench: early-exit and constant-latency instances side by side,
// vector table, hand sequences (back-pressure, reset) and random ops vs a model.
module tb_branch_cmp_seq;

  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            br_un;
  logic            out_ready;

  logic ready0, valid0, less0, equal0;
  logic ready1, valid1, less1, equal1;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        un;
    logic        lt;
    logic        eq;
    int          k;
  } vec_t;

  vec_t vt[8];

  branch_cmp_seq #(.XLEN(XLEN), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) u_dut_ee (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ready0),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
    .o_valid(valid0), .i_ready(out_ready), .o_br_less(less0), .o_br_equal(equal0)
  );

  branch_cmp_seq #(.XLEN(XLEN), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) u_dut_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ready1),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
    .o_valid(valid1), .i_ready(out_ready), .o_br_less(less1), .o_br_equal(equal1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned compare; latency from the top differing chunk.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic un,
                       output logic lt, output logic eq, output int k);
    logic [31:0] x;
    logic        found;
    eq = (a == b);
    lt = un ? (a < b) : ($signed(a) < $signed(b));
    x = a ^ b;
    k = NCHUNK;
    found = 1'b0;
    for (int h = NCHUNK - 1; h >= 0; h--) begin
      if (!found && (((x >> (h * CHUNK)) & 32'hFF) != 0)) begin
        found = 1'b1;
        k = NCHUNK - h;
      end
    end
  endtask

  // Present one request; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic un);
    @(negedge clk);
    check("ready_before_accept_ee", 32'(ready0), 32'd1);
    check("ready_before_accept_full", 32'(ready1), 32'd1);
    rs1 = a; rs2 = b; br_un = un; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; br_un = ~un;
  endtask

  // Count edges to o_valid on both instances and check the results.
  task automatic collect(input string tag, input logic lt, input logic eq, input int k_ee);
    int k0, k1;
    k0 = -1; k1 = -1;
    for (int c = 1; c <= 20 && (k0 < 0 || k1 < 0); c++) begin
      @(posedge clk); #1;
      if (valid0 && k0 < 0) k0 = c;
      if (valid1 && k1 < 0) k1 = c;
    end
    check({tag, "_k_ee"}, 32'(k0), 32'(k_ee));
    check({tag, "_k_full"}, 32'(k1), 32'(NCHUNK));
    check({tag, "_less_ee"}, 32'(less0), 32'(lt));
    check({tag, "_equal_ee"}, 32'(equal0), 32'(eq));
    check({tag, "_less_full"}, 32'(less1), 32'(lt));
    check({tag, "_equal_full"}, 32'(equal1), 32'(eq));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(valid0 | valid1), 32'd0);
    check({tag, "_ready_back"}, 32'(ready0 & ready1), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_model_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic un);
    logic lt, eq;
    int   k;
    model(a, b, un, lt, eq, k);
    start_op(a, b, un);
    collect(tag, lt, eq, k);
    release_result(tag);
  endtask

  initial begin
    logic        held_less;
    logic        lt, eq;
    int          k;
    logic [31:0] a, b;

    n_cmp = 0; n_err = 0;
    in_valid = 1'b0; rs1 = '0; rs2 = '0; br_un = 1'b1; out_ready = 1'b0;

    vt[0] = '{32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1};
    vt[1] = '{32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
    vt[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1};
    vt[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 4};
    vt[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 4};
    vt[5] = '{32'h1234_5670, 32'h1234_5671, 1'b1, 1'b1, 1'b0, 4};
    vt[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
    vt[7] = '{32'h0001_0000, 32'h0001_FF00, 1'b0, 1'b1, 1'b0, 3};

    rst_n = 1'b0;
    #13;
    check("rst_valid", 32'(valid0 | valid1), 32'd0);
    check("rst_less", 32'(less0 | less1), 32'd0);
    check("rst_equal", 32'(equal0 | equal1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(ready0 & ready1), 32'd1);

    for (int i = 0; i < 8; i++) begin
      start_op(vt[i].a, vt[i].b, vt[i].un);
      collect($sformatf("vec%0d", i), vt[i].lt, vt[i].eq, vt[i].k);
      check($sformatf("vec%0d_not_both", i), 32'(less0 & equal0), 32'd0);
      release_result($sformatf("vec%0d", i));
    end

    // Back-pressure: result held while a new request waits outside.
    start_op(32'h0000_0001, 32'h8000_0000, 1'b1);
    collect("bp_first", 1'b1, 1'b0, 1);
    held_less = less0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rs1 = 32'h0000_0010; rs2 = 32'h0000_0020; br_un = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_held", 32'(valid0 & valid1), 32'd1);
      check("bp_less_stable", 32'(less0), 32'(held_less));
      check("bp_ready_low", 32'(ready0 | ready1), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(ready0 & ready1), 32'd1);
    check("bp_release_valid", 32'(valid0 | valid1), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    collect("bp_second", 1'b1, 1'b0, 4);
    release_result("bp_second");

    // Reset during S_CMP (index 2): aborted op never reports.
    start_op(32'h0000_0007, 32'h0000_0007, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstcmp_valid", 32'(valid0 | valid1), 32'd0);
    check("rstcmp_less", 32'(less0 | less1), 32'd0);
    check("rstcmp_equal", 32'(equal0 | equal1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstcmp_ready", 32'(ready0 & ready1), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rstcmp_no_stale", 32'(valid0 | valid1), 32'd0);
    end
    start_op(32'h0000_0005, 32'h0000_0005, 1'b1);
    collect("rstcmp_next", 1'b0, 1'b1, 4);
    release_result("rstcmp_next");

    // Reset while a less=1 result is held clears it at once.
    start_op(32'h0000_0001, 32'h8000_0000, 1'b1);
    collect("rstdone_pre", 1'b1, 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstdone_valid", 32'(valid0 | valid1), 32'd0);
    check("rstdone_less", 32'(less0 | less1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random operations, biased toward single-chunk and near-equal differences.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        2: b = a;
        default: b = a ^ (32'd1 << $urandom_range(0, 31));
      endcase
      model(a, b, 1'(($urandom & 1)), lt, eq, k);
      run_model_op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
